// File: rtl/sort_array_bubble_imp.sv
// In-place ascending bubble sort of M[0..LAST_IDX] with early exit; one compare per clock, e.g. 9..45 COMP cycles for ten elements.
// No backpressure: Start is sampled in INI, the result is held in DONE until Ack, and TOP performs the swap on every Swap strobe.
module sort_array_bubble_imp #(
  parameter logic [3:0] LAST_IDX = 4'd9
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic [3:0] Ms_of_I,
  input  logic [3:0] Ms_of_Ip1,
  output logic [3:0] I,
  output logic       Swap,
  output logic [6:0] SwapCount,
  output logic       Done
);

  typedef enum logic [2:0] {
    INI  = 3'b001,
    COMP = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_i;
  logic [3:0] r_lim;
  logic       r_swapped;
  logic [6:0] r_swap_count;
  logic       w_end_pass;
  logic       w_finish;

  assign I         = r_i;
  assign SwapCount = r_swap_count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= INI;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    Swap       = 1'b0;
    Done       = 1'b0;
    w_end_pass = (r_i == r_lim);
    w_finish   = 1'b0;
    case (r_state)
      INI: begin
        if (Start) w_next = COMP;
      end
      COMP: begin
        // Strict compare keeps equal elements in order.
        Swap     = (Ms_of_I > Ms_of_Ip1);
        w_finish = w_end_pass && (!(r_swapped || Swap) || (r_lim == 4'd0));
        if (w_finish) w_next = DONE;
      end
      DONE: begin
        Done = 1'b1;
        if (Ack) w_next = INI;
      end
      default: w_next = state_t'(3'bxxx);
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_i          <= 'x;
      r_lim        <= 'x;
      r_swapped    <= 1'bx;
      r_swap_count <= 'x;
    end else begin
      case (r_state)
        INI: begin
          r_i          <= 4'd0;
          r_lim        <= LAST_IDX - 4'd1;
          r_swapped    <= 1'b0;
          r_swap_count <= 7'd0;
        end
        COMP: begin
          if (Swap) begin
            r_swapped    <= 1'b1;
            r_swap_count <= r_swap_count + 7'd1;
          end
          if (!w_end_pass) begin
            r_i <= r_i + 4'd1;
          end else if (!w_finish) begin
            // Last element of this pass is now in place; shrink the window.
            r_i       <= 4'd0;
            r_lim     <= r_lim - 4'd1;
            r_swapped <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_array_bubble_imp.sv
// Directed bench for sort_array_bubble_imp: holds the array, performs swaps, checks results, latency and strobe behaviour.
module tb_sort_array_bubble_imp;

  localparam logic [3:0] LAST_IDX = 4'd9;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic [3:0] Ms_of_I;
  logic [3:0] Ms_of_Ip1;
  logic [3:0] I;
  logic       Swap;
  logic [6:0] SwapCount;
  logic       Done;

  logic [3:0]  m [16];
  logic        ld_en;
  logic [39:0] ld_val;

  int checks   = 0;
  int failures = 0;

  sort_array_bubble_imp #(.LAST_IDX(LAST_IDX)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .Ms_of_I   (Ms_of_I),
    .Ms_of_Ip1 (Ms_of_Ip1),
    .I         (I),
    .Swap      (Swap),
    .SwapCount (SwapCount),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  assign Ms_of_I   = m[I];
  assign Ms_of_Ip1 = m[I + 4'd1];

  always @(posedge Clk) begin
    if (ld_en) begin
      for (int k = 0; k < 10; k++) m[k] <= ld_val[39-4*k -: 4];
      for (int k = 10; k < 16; k++) m[k] <= 4'd0;
    end else if (Swap) begin
      m[I]        <= m[I + 4'd1];
      m[I + 4'd1] <= m[I];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] mem_vec();
    logic [39:0] v;
    for (int k = 0; k < 10; k++) v[39-4*k -: 4] = m[k];
    return v;
  endfunction

  task automatic load(input logic [39:0] v);
    ld_val = v;
    ld_en  = 1'b1;
    @(posedge Clk); #1;
    ld_en  = 1'b0;
  endtask

  task automatic do_ack(input string tag);
    Ack = 1'b1;
    @(posedge Clk); #1;
    Ack = 1'b0;
    chk({tag, "_done_after_ack"}, Done, 1'b0);
  endtask

  // Starts (optionally after loading), waits for Done and checks the run; leaves the DUT in DONE.
  task automatic sort_run(input string tag, input bit do_load, input logic [39:0] init,
                          input logic [39:0] exp_m, input int exp_cyc, input int exp_sc);
    int n, sw, eqsw, badi;
    if (do_load) load(init);
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    n = 0; sw = 0; eqsw = 0; badi = 0;
    while (!Done && n < 200) begin
      if (Swap) sw++;
      if (Swap && (Ms_of_I == Ms_of_Ip1)) eqsw++;
      if (I > LAST_IDX - 4'd1) badi++;
      @(posedge Clk); #1;
      n++;
    end
    chk({tag, "_cycles"}, n, exp_cyc);
    chk({tag, "_swapcount"}, SwapCount, exp_sc);
    chk({tag, "_strobes"}, sw, exp_sc);
    chk({tag, "_mem"}, mem_vec(), exp_m);
    chk({tag, "_equal_swaps"}, eqsw, 0);
    chk({tag, "_index_bound"}, badi, 0);
  endtask

  localparam logic [39:0] SORTED = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  localparam logic [39:0] REVRS  = {4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  localparam logic [39:0] DUPS   = {4'd3, 4'd1, 4'd3, 4'd0, 4'd15, 4'd15, 4'd7, 4'd1, 4'd0, 4'd8};
  localparam logic [39:0] DUPS_S = {4'd0, 4'd0, 4'd1, 4'd1, 4'd3, 4'd3, 4'd7, 4'd8, 4'd15, 4'd15};
  localparam logic [39:0] ONEOFF = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
  localparam logic [39:0] MIDRST = {4'd7, 4'd6, 4'd8, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0; ld_en = 1'b0; ld_val = '0;
    #1;
    chk("reset_done", Done, 1'b0);
    chk("reset_swap", Swap, 1'b0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;

    sort_run("sorted", 1'b1, SORTED, SORTED, 9, 0);
    do_ack("sorted");

    sort_run("reversed", 1'b1, REVRS, SORTED, 45, 45);
    do_ack("reversed");

    sort_run("dups", 1'b1, DUPS, DUPS_S, 44, 20);
    do_ack("dups");

    sort_run("oneoff", 1'b1, ONEOFF, SORTED, 45, 9);
    do_ack("oneoff");

    // Reset two compares into pass 2 of the reversed case.
    load(REVRS);
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (11) @(posedge Clk);
    #1;
    chk("midrst_mem", mem_vec(), MIDRST);
    chk("midrst_swap_before", Swap, 1'b1);
    Reset = 1'b1;
    #1;
    chk("midrst_swap", Swap, 1'b0);
    chk("midrst_done", Done, 1'b0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("midrst_mem_kept", mem_vec(), MIDRST);
    sort_run("resume", 1'b0, MIDRST, SORTED, 45, 34);

    // Start alone in DONE is ignored.
    Start = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    chk("done_hold", Done, 1'b1);
    chk("done_hold_sc", SwapCount, 34);
    Ack = 1'b1;
    @(posedge Clk); #1;
    Ack = 1'b0;
    chk("start_ack_ini", Done, 1'b0);
    n = 0;
    while (!Done && n < 200) begin
      @(posedge Clk); #1;
      n++;
      Start = 1'b0;
    end
    chk("restart_cycles", n, 10);
    chk("restart_swapcount", SwapCount, 0);
    chk("restart_mem", mem_vec(), SORTED);
    do_ack("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
